// File: rtl/branch_tag_unit_pkg.sv
// Shared backend types for the EBR branch-tag pool: tag/mask widths and the
// registered branch-resolution record.
package backend_types;

    localparam int NUM_TAGS = 4;
    localparam int TAG_W    = $clog2(NUM_TAGS);

    typedef logic [TAG_W-1:0]    branch_tag_t;
    typedef logic [NUM_TAGS-1:0] branch_mask_t;

    typedef struct packed {
        branch_tag_t tag;
        logic        mispredict;
        logic [31:0] target;
    } brb_result_t;

    function automatic branch_mask_t tag_onehot(input branch_tag_t t);
        branch_mask_t m;
        m    = '0;
        m[t] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/brb_itf.sv
// Branch broadcast bus: one resolved tag per cycle, flagged clean or kill.
interface brb_itf #(
    parameter int TAG_W = 2
);
    logic             broadcast;
    logic [TAG_W-1:0] tag;
    logic             clean;
    logic             kill;

    modport responder (output broadcast, output tag, output clean, output kill);
    modport consumer  (input broadcast, input tag, input clean, input kill);
endinterface

// File: rtl/branch_tag_unit_freelist.sv
// Busy vector of the branch-tag pool with lowest-free-tag priority encoder and
// full detect. Frees (clr_mask) and grants (set_mask) apply on the same edge.
module branch_tag_freelist #(
    parameter int NUM_TAGS = 4,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_TAGS-1:0] set_mask,
    input  logic [NUM_TAGS-1:0] clr_mask,
    output logic [NUM_TAGS-1:0] busy,
    output logic [TAG_W-1:0]    free_tag,
    output logic                full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    // Scan downward so the lowest free index wins.
    always_comb begin
        free_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_tag = TAG_W'(i);
            end
        end
    end

    assign full = &busy;

endmodule

// File: rtl/branch_tag_unit.sv
// EBR branch-tag pool: tag allocation at dispatch, resolution broadcast
// (clean/kill) and front-end redirect. Optional counters under BRANCH_STATS_EN.
module branch_tag_unit #(
    parameter int NUM_TAGS = backend_types::NUM_TAGS,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_req,
    output logic                alloc_ready,
    output logic [TAG_W-1:0]    alloc_tag,
    output logic [NUM_TAGS-1:0] live_mask,
    input  logic                res_valid,
    input  logic [TAG_W-1:0]    res_tag,
    input  logic                res_mispredict,
    input  logic [31:0]         res_target,
    output logic                res_ready,
    output logic                brb_broadcast,
    output logic [TAG_W-1:0]    brb_tag,
    output logic                brb_clean,
    output logic                brb_kill,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]         stat_resolved,
    output logic [31:0]         stat_mispredict
`endif
);
    import backend_types::*;

    logic [NUM_TAGS-1:0] busy;
    logic [TAG_W-1:0]    free_tag;
    logic                full;
    logic [NUM_TAGS-1:0] set_mask;
    logic [NUM_TAGS-1:0] clr_mask;
    logic [NUM_TAGS-1:0] dep_mask [NUM_TAGS];
    logic [NUM_TAGS-1:0] live_q;
    logic [NUM_TAGS-1:0] bc_onehot;
    logic [NUM_TAGS-1:0] squash;
    logic                clean_now;
    logic                kill_now;
    logic                alloc_fire;
    logic                res_accept;

    logic                vld_p1;
    brb_result_t         res_p1;

    branch_tag_freelist #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_freelist (
        .clk      (clk),
        .rst      (rst),
        .set_mask (set_mask),
        .clr_mask (clr_mask),
        .busy     (busy),
        .free_tag (free_tag),
        .full     (full)
    );

    assign bc_onehot = NUM_TAGS'(1) << res_p1.tag;
    assign clean_now = vld_p1 & ~res_p1.mispredict;
    assign kill_now  = vld_p1 &  res_p1.mispredict;

    // Squash set of a kill: the tag itself plus every live branch younger than it.
    always_comb begin
        squash = '0;
        if (kill_now) begin
            squash = bc_onehot;
            for (int x = 0; x < NUM_TAGS; x++) begin
                if (busy[x] && dep_mask[x][res_p1.tag]) begin
                    squash[x] = 1'b1;
                end
            end
        end
    end

    assign clr_mask    = kill_now ? squash : (clean_now ? bc_onehot : '0);
    assign live_mask   = live_q & ~(clean_now ? bc_onehot : '0);
    assign alloc_ready = ~full & ~kill_now;
    assign alloc_tag   = free_tag;
    assign alloc_fire  = alloc_req & alloc_ready;
    assign set_mask    = alloc_fire ? (NUM_TAGS'(1) << free_tag) : '0;
    assign res_accept  = res_valid & busy[res_tag] & ~squash[res_tag];
    assign res_ready   = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= '0;
        end else begin
            live_q <= (live_q & ~clr_mask) | set_mask;
        end
    end

    // A fresh grant captures the bypassed live mask, so a same-cycle clean never leaks in.
    always_ff @(posedge clk) begin
        for (int x = 0; x < NUM_TAGS; x++) begin
            if (rst) begin
                dep_mask[x] <= '0;
            end else if (set_mask[x]) begin
                dep_mask[x] <= live_mask;
            end else if (squash[x]) begin
                dep_mask[x] <= '0;
            end else if (clean_now) begin
                dep_mask[x] <= dep_mask[x] & ~bc_onehot;
            end
        end
    end

    // ---- stage p1: registered resolution driving the broadcast bus ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
        end else begin
            vld_p1 <= res_accept;
            if (res_accept) begin
                res_p1.tag        <= res_tag;
                res_p1.mispredict <= res_mispredict;
                res_p1.target     <= res_target;
            end else begin
                res_p1 <= '0;
            end
        end
    end

    brb_itf #(.TAG_W(TAG_W)) brb ();

    assign brb.broadcast = vld_p1;
    assign brb.tag       = res_p1.tag;
    assign brb.clean     = clean_now;
    assign brb.kill      = kill_now;

    assign brb_broadcast  = brb.broadcast;
    assign brb_tag        = brb.tag;
    assign brb_clean      = brb.clean;
    assign brb_kill       = brb.kill;
    assign redirect_valid = kill_now;
    assign redirect_pc    = res_p1.target;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else if (vld_p1) begin
            stat_resolved <= stat_resolved + 32'd1;
            if (res_p1.mispredict) begin
                stat_mispredict <= stat_mispredict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_tag_unit.sv
// Bench for branch_tag_unit: directed scenarios plus randomized traffic against
// a tag-pool reference model. Stats checks compile in with BRANCH_STATS_EN.
module tb_branch_tag_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_req = 1'b0;
    logic        alloc_ready;
    logic [1:0]  alloc_tag;
    logic [3:0]  live_mask;
    logic        res_valid = 1'b0;
    logic [1:0]  res_tag = '0;
    logic        res_mispredict = 1'b0;
    logic [31:0] res_target = '0;
    logic        res_ready;
    logic        brb_broadcast;
    logic [1:0]  brb_tag;
    logic        brb_clean;
    logic        brb_kill;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_tag_unit dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .live_mask      (live_mask),
        .res_valid      (res_valid),
        .res_tag        (res_tag),
        .res_mispredict (res_mispredict),
        .res_target     (res_target),
        .res_ready      (res_ready),
        .brb_broadcast  (brb_broadcast),
        .brb_tag        (brb_tag),
        .brb_clean      (brb_clean),
        .brb_kill       (brb_kill),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BRANCH_STATS_EN
        ,
        .stat_resolved  (stat_resolved),
        .stat_mispredict(stat_mispredict)
`endif
    );

    // Reference model: which tags are in flight, who each depends on, and the
    // result currently on the broadcast bus.
    bit          m_busy [4];
    bit [3:0]    m_dep  [4];
    bit [3:0]    m_live;
    bit          m_bv;
    int          m_bt;
    bit          m_bm;
    logic [31:0] m_btgt;
    int unsigned m_res;
    int unsigned m_mis;

    function automatic bit [3:0] m_squash();
        bit [3:0] s = '0;
        if (m_bv && m_bm) begin
            s[m_bt] = 1'b1;
            for (int x = 0; x < 4; x++)
                if (m_busy[x] && m_dep[x][m_bt]) s[x] = 1'b1;
        end
        return s;
    endfunction

    function automatic bit [3:0] m_live_now();
        bit [3:0] l = m_live;
        if (m_bv && !m_bm) l[m_bt] = 1'b0;
        return l;
    endfunction

    function automatic bit m_ready();
        int n = 0;
        for (int x = 0; x < 4; x++) if (m_busy[x]) n++;
        return (n < 4) && !(m_bv && m_bm);
    endfunction

    function automatic int m_free();
        for (int x = 0; x < 4; x++) if (!m_busy[x]) return x;
        return 0;
    endfunction

    task automatic model_step();
        bit [3:0] s;
        bit [3:0] ln;
        bit       rdy;
        int       ft;
        bit       acc;
        if (rst) begin
            for (int x = 0; x < 4; x++) begin
                m_busy[x] = 1'b0;
                m_dep[x]  = '0;
            end
            m_live = '0; m_bv = 1'b0; m_bt = 0; m_bm = 1'b0; m_btgt = '0;
            m_res = 0; m_mis = 0;
            return;
        end
        s   = m_squash();
        ln  = m_live_now();
        rdy = m_ready();
        ft  = m_free();
        acc = res_valid && m_busy[res_tag] && !s[res_tag];
        if (m_bv) begin
            m_res++;
            if (m_bm) m_mis++;
        end
        if (m_bv && !m_bm) begin
            m_busy[m_bt] = 1'b0;
            m_live[m_bt] = 1'b0;
            for (int x = 0; x < 4; x++) m_dep[x][m_bt] = 1'b0;
        end
        if (m_bv && m_bm) begin
            for (int x = 0; x < 4; x++)
                if (s[x]) begin
                    m_busy[x] = 1'b0;
                    m_live[x] = 1'b0;
                    m_dep[x]  = '0;
                end
        end
        if (alloc_req && rdy) begin
            m_busy[ft] = 1'b1;
            m_dep[ft]  = ln;
            m_live[ft] = 1'b1;
        end
        m_bv   = acc;
        m_bt   = res_tag;
        m_bm   = res_mispredict;
        m_btgt = res_target;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req = 1'b0; res_valid = 1'b0; res_tag = '0;
        res_mispredict = 1'b0; res_target = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill(input int n);
        alloc_req = 1'b1;
        repeat (n) tick();
        alloc_req = 1'b0;
    endtask

    task automatic send_res(input int t, input bit mis, input logic [31:0] tgt);
        res_valid = 1'b1; res_tag = 2'(t); res_mispredict = mis; res_target = tgt;
        tick();
        res_valid = 1'b0; res_mispredict = 1'b0; res_target = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        vectors++; if (alloc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready); end
        vectors++; if (res_ready !== 1'b1) begin miscompares++; $display("FAIL reset_res_ready: got %0b expected 1", res_ready); end
        vectors++; if (live_mask !== 4'b0000) begin miscompares++; $display("FAIL reset_live_mask: got %b expected 0000", live_mask); end
        vectors++; if ({brb_broadcast, brb_clean, brb_kill, redirect_valid} !== 4'b0) begin miscompares++; $display("FAIL reset_brb: got %b expected 0000", {brb_broadcast, brb_clean, brb_kill, redirect_valid}); end
        vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
        vectors++; if (alloc_tag !== 2'd0) begin miscompares++; $display("FAIL reset_alloc_tag: got %0d expected 0", alloc_tag); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_live [4];
        exp_live[0] = 4'b0000; exp_live[1] = 4'b0001; exp_live[2] = 4'b0011; exp_live[3] = 4'b0111;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1;
            #2;
            vectors++; if (alloc_tag !== 2'(i)) begin miscompares++; $display("FAIL b2b_tag%0d: got %0d expected %0d", i, alloc_tag, i); end
            vectors++; if (live_mask !== exp_live[i]) begin miscompares++; $display("FAIL b2b_live%0d: got %b expected %b", i, live_mask, exp_live[i]); end
            vectors++; if (alloc_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %0b expected 1", i, alloc_ready); end
            tick();
        end
        alloc_req = 1'b0;
        #2;
        vectors++; if (alloc_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full: got %0b expected 0", alloc_ready); end
        vectors++; if (live_mask !== 4'b1111) begin miscompares++; $display("FAIL b2b_live_full: got %b expected 1111", live_mask); end
    endtask

    task automatic test_clean();
        do_reset();
        fill(4);
        send_res(1, 1'b0, 32'h1234);
        #2;
        vectors++; if ({brb_broadcast, brb_clean, brb_kill} !== 3'b110) begin miscompares++; $display("FAIL clean_flags: got %b expected 110", {brb_broadcast, brb_clean, brb_kill}); end
        vectors++; if (brb_tag !== 2'd1) begin miscompares++; $display("FAIL clean_tag: got %0d expected 1", brb_tag); end
        vectors++; if (live_mask !== 4'b1101) begin miscompares++; $display("FAIL clean_bypass: got %b expected 1101", live_mask); end
        vectors++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL clean_redirect: got %0b expected 0", redirect_valid); end
        vectors++; if (alloc_ready !== 1'b0) begin miscompares++; $display("FAIL clean_no_reuse: got %0b expected 0", alloc_ready); end
        tick();
        #2;
        vectors++; if (alloc_ready !== 1'b1 || alloc_tag !== 2'd1) begin miscompares++; $display("FAIL clean_realloc: got ready=%0b tag=%0d expected ready=1 tag=1", alloc_ready, alloc_tag); end
        vectors++; if (brb_broadcast !== 1'b0) begin miscompares++; $display("FAIL clean_pulse: got %0b expected 0", brb_broadcast); end
        // Tag 2 no longer depends on tag 1: killing tag 1's successor only squashes 2 and 3 via tag 0's kill path is not needed; kill tag 2 and tag 3 must go, tag 0 stays.
        send_res(2, 1'b1, 32'h0);
        tick();
        #2;
        vectors++; if (live_mask !== 4'b0001) begin miscompares++; $display("FAIL clean_dep_cleared: got %b expected 0001", live_mask); end
    endtask

    task automatic test_kill();
        do_reset();
        fill(4);
        send_res(1, 1'b1, 32'h8000_0040);
        #2;
        vectors++; if ({brb_broadcast, brb_clean, brb_kill, redirect_valid} !== 4'b1011) begin miscompares++; $display("FAIL kill_flags: got %b expected 1011", {brb_broadcast, brb_clean, brb_kill, redirect_valid}); end
        vectors++; if (brb_tag !== 2'd1) begin miscompares++; $display("FAIL kill_tag: got %0d expected 1", brb_tag); end
        vectors++; if (redirect_pc !== 32'h8000_0040) begin miscompares++; $display("FAIL kill_redirect_pc: got %h expected 80000040", redirect_pc); end
        vectors++; if (alloc_ready !== 1'b0) begin miscompares++; $display("FAIL kill_ready: got %0b expected 0", alloc_ready); end
        tick();
        #2;
        vectors++; if (live_mask !== 4'b0001) begin miscompares++; $display("FAIL kill_live: got %b expected 0001", live_mask); end
        vectors++; if (alloc_ready !== 1'b1 || alloc_tag !== 2'd1) begin miscompares++; $display("FAIL kill_freed: got ready=%0b tag=%0d expected ready=1 tag=1", alloc_ready, alloc_tag); end
        vectors++; if (redirect_valid !== 1'b0 || brb_broadcast !== 1'b0) begin miscompares++; $display("FAIL kill_pulse: got rv=%0b bc=%0b expected 0 0", redirect_valid, brb_broadcast); end
    endtask

    task automatic test_kill_filter();
        do_reset();
        fill(4);
        send_res(0, 1'b1, 32'h4000);
        res_valid = 1'b1; res_tag = 2'd2; res_mispredict = 1'b0;
        #2;
        vectors++; if (brb_kill !== 1'b1 || brb_tag !== 2'd0) begin miscompares++; $display("FAIL filter_kill: got kill=%0b tag=%0d expected 1 0", brb_kill, brb_tag); end
        tick();
        res_valid = 1'b0;
        #2;
        vectors++; if (brb_broadcast !== 1'b0) begin miscompares++; $display("FAIL filter_dropped: got %0b expected 0", brb_broadcast); end
        vectors++; if (live_mask !== 4'b0000) begin miscompares++; $display("FAIL filter_live: got %b expected 0000", live_mask); end
        // Result for a tag that is not allocated must be dropped as well.
        send_res(3, 1'b0, 32'h0);
        #2;
        vectors++; if (brb_broadcast !== 1'b0) begin miscompares++; $display("FAIL filter_unalloc: got %0b expected 0", brb_broadcast); end
    endtask

    task automatic test_alloc_during_clean();
        do_reset();
        fill(3);
        send_res(0, 1'b0, 32'h0);
        alloc_req = 1'b1;
        #2;
        vectors++; if (alloc_tag !== 2'd3 || alloc_ready !== 1'b1) begin miscompares++; $display("FAIL adc_grant: got tag=%0d ready=%0b expected 3 1", alloc_tag, alloc_ready); end
        vectors++; if (live_mask !== 4'b0110) begin miscompares++; $display("FAIL adc_live: got %b expected 0110", live_mask); end
        tick();
        alloc_req = 1'b0;
        #2;
        vectors++; if (live_mask !== 4'b1110 || alloc_tag !== 2'd0) begin miscompares++; $display("FAIL adc_after: got live=%b tag=%0d expected 1110 0", live_mask, alloc_tag); end
        // Tag 3 captured dependency on tag 1, so killing 1 empties the pool.
        send_res(1, 1'b1, 32'h0);
        tick();
        #2;
        vectors++; if (live_mask !== 4'b0000) begin miscompares++; $display("FAIL adc_dep: got %b expected 0000", live_mask); end
    endtask

    task automatic test_reset_mid_broadcast();
        do_reset();
        fill(4);
        send_res(2, 1'b1, 32'hDEAD_BEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        vectors++; if ({brb_broadcast, brb_kill, redirect_valid} !== 3'b000) begin miscompares++; $display("FAIL rstmid_brb: got %b expected 000", {brb_broadcast, brb_kill, redirect_valid}); end
        vectors++; if (live_mask !== 4'b0000 || alloc_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_pool: got live=%b ready=%0b expected 0000 1", live_mask, alloc_ready); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fill(1);
            send_res(0, (i < 2), 32'h0);
            tick();
        end
        #2;
        vectors++; if (stat_resolved !== 32'd5) begin miscompares++; $display("FAIL stats_resolved: got %0d expected 5", stat_resolved); end
        vectors++; if (stat_mispredict !== 32'd2) begin miscompares++; $display("FAIL stats_mispredict: got %0d expected 2", stat_mispredict); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        vectors++; if (stat_resolved !== 32'd0 || stat_mispredict !== 32'd0) begin miscompares++; $display("FAIL stats_reset: got %0d %0d expected 0 0", stat_resolved, stat_mispredict); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst            = ($urandom_range(0, 149) == 0);
            alloc_req      = ($urandom_range(0, 9) < 6);
            res_valid      = ($urandom_range(0, 1) == 1);
            res_tag        = 2'($urandom_range(0, 3));
            res_mispredict = ($urandom_range(0, 4) == 0);
            res_target     = $urandom;
            #2;
            vectors++;
            if (alloc_ready !== m_ready() || live_mask !== m_live_now() || brb_broadcast !== m_bv
                || (m_ready() && alloc_tag !== 2'(m_free()))
                || (m_bv && (brb_tag !== 2'(m_bt) || brb_clean !== !m_bm || brb_kill !== m_bm))
                || redirect_valid !== (m_bv && m_bm)
                || (m_bv && m_bm && redirect_pc !== m_btgt)
`ifdef BRANCH_STATS_EN
                || stat_resolved !== m_res || stat_mispredict !== m_mis
`endif
                ) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got ready=%0b tag=%0d live=%b bc=%0b btag=%0d cl=%0b kl=%0b rv=%0b pc=%h required ready=%0b tag=%0d live=%b bc=%0b btag=%0d kill=%0b pc=%h",
                         n, alloc_ready, alloc_tag, live_mask, brb_broadcast, brb_tag, brb_clean, brb_kill, redirect_valid, redirect_pc,
                         m_ready(), m_free(), m_live_now(), m_bv, m_bt, m_bm, m_btgt);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_clean();
        test_kill();
        test_kill_filter();
        test_alloc_during_clean();
        test_reset_mid_broadcast();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
